lvds_rx_deframer: RTL and testbench

Parametrised multi-lane successor to the single-lane LVDS receiver. Takes LANES×2 bits per clk from the external DDR input primitives and locks on a zero-run preamble with bit-granular alignment. Once locked, it assembles FRAME_LEN MSB-first bytes per frame into an internal synchronous FIFO, which the downstream SDR datapath drains through a rd_en/rd_dr interface. The block is fully single-clock; the DDR capture cells are instantiated by the parent.

---
 rtl/lvds_rx_pkg.sv | 43 ++++
 rtl/lvds_rx_deframer_fifo.sv | 54 +++++
 rtl/lvds_rx_deframer.sv | 145 ++++++++++++++
 tb/tb_lvds_rx_deframer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared types, constants and zero-count helpers for the LVDS receive deframer.
package lvds_rx_pkg;

    typedef enum logic [1:0] {
        INIT,
        ZEROS,
        RUN
    } state_t;

    localparam int BYTE_W   = 8;
    localparam int ZCNT_MAX = 255;

    // Zeros before the first 1, scanning from bit bpc-1 (earliest) downwards.
    function automatic int lzc(input logic [7:0] w, input int bpc);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (int'(i) < bpc && !seen) begin
                if (w[3'(bpc - 1 - int'(i))]) seen = 1'b1;
                else                          n++;
            end
        end
        return n;
    endfunction

    // Zeros after the last 1, scanning from bit 0 (latest) upwards.
    function automatic int tzc(input logic [7:0] w, input int bpc);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (int'(i) < bpc && !seen) begin
                if (w[3'(i)]) seen = 1'b1;
                else          n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lvds_rx_deframer_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered read port.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int                DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push;
    logic                pop;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push.
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            rd_valid <= pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/lvds_rx_deframer.sv
// Multi-lane LVDS deframer: zero-run preamble lock, bit-aligned byte assembly into a FIFO.
module lvds_rx_deframer
    import lvds_rx_pkg::*;
#(
    parameter int LANES      = 1,
    parameter int ZERO_LEN   = 10,
    parameter int FRAME_LEN  = 64,
    parameter int DEPTH_LOG2 = 8,
    parameter int AF_THRESH  = 224,
    parameter int AE_THRESH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2*LANES-1:0]    in_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  rd_dr,
    output logic [DEPTH_LOG2:0]   data_count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  locked,
    output logic                  frame_done,
    output logic                  overflow
);
    localparam int BPC = 2 * LANES;

    state_t      state, state_n;
    logic [7:0]  zcnt, zcnt_n;
    logic [15:0] acc, acc_n;
    logic [4:0]  acc_cnt, acc_cnt_n;
    logic [15:0] byte_cnt, byte_cnt_n;

    logic [7:0]  word;
    logic [15:0] merged;
    logic [4:0]  merged_cnt;
    int          lead;
    int          zsum;
    logic [7:0]  byte_out;
    logic        byte_vld;
    logic        last_byte;
    logic        fifo_full;
    logic        fifo_empty;

    assign word = 8'(in_data);

    always_comb begin
        state_n    = state;
        zcnt_n     = zcnt;
        acc_n      = acc;
        acc_cnt_n  = acc_cnt;
        byte_cnt_n = byte_cnt;
        byte_out   = '0;
        byte_vld   = 1'b0;
        last_byte  = 1'b0;
        lead       = lzc(word, BPC);
        zsum       = int'(zcnt) + lead;
        // Newest bits sit at the LSB end; only the low acc_cnt bits are meaningful.
        merged     = (acc << BPC) | 16'(in_data);
        merged_cnt = acc_cnt + 5'(BPC);

        case (state)
            INIT: begin
                state_n    = ZEROS;
                zcnt_n     = '0;
                acc_n      = '0;
                acc_cnt_n  = '0;
                byte_cnt_n = '0;
            end
            ZEROS: begin
                if (word == '0) begin
                    zcnt_n = (int'(zcnt) + BPC >= ZCNT_MAX) ? 8'(ZCNT_MAX) : zcnt + 8'(BPC);
                end else if (zsum >= ZERO_LEN) begin
                    state_n    = RUN;
                    acc_n      = 16'(in_data);
                    acc_cnt_n  = 5'(BPC - 1 - lead);
                    byte_cnt_n = '0;
                end else begin
                    zcnt_n = 8'(tzc(word, BPC));
                end
            end
            RUN: begin
                acc_n     = merged;
                acc_cnt_n = merged_cnt;
                if (merged_cnt >= 5'(BYTE_W)) begin
                    byte_vld   = 1'b1;
                    byte_out   = 8'(merged >> (merged_cnt - 5'(BYTE_W)));
                    acc_cnt_n  = merged_cnt - 5'(BYTE_W);
                    byte_cnt_n = byte_cnt + 16'd1;
                    if (byte_cnt == 16'(FRAME_LEN - 1)) begin
                        last_byte  = 1'b1;
                        state_n    = ZEROS;
                        zcnt_n     = '0;
                        acc_n      = '0;
                        acc_cnt_n  = '0;
                        byte_cnt_n = '0;
                    end
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= INIT;
            zcnt       <= '0;
            acc        <= '0;
            acc_cnt    <= '0;
            byte_cnt   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            zcnt       <= zcnt_n;
            acc        <= acc_n;
            acc_cnt    <= acc_cnt_n;
            byte_cnt   <= byte_cnt_n;
            frame_done <= last_byte;
            if (byte_vld && fifo_full) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (byte_vld),
        .wr_data  (byte_out),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (data_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign locked       = (state == RUN);
    assign rd_dr        = !fifo_empty;
    assign almost_full  = (int'(data_count) >= AF_THRESH);
    assign almost_empty = (int'(data_count) <= AE_THRESH);

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Bench for lvds_rx_deframer: two instances (1 lane / 4 lanes) against a bit-serial reference model.
module tb_lvds_rx_deframer;
    localparam int ZL    = 10;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 3;
    localparam int FL_A  = 2;
    localparam int FL_B  = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] din_a;
    logic [7:0] din_b;
    logic       re_a, re_b;
    logic [7:0] rdd_a, rdd_b;
    logic       rv_a, rv_b, dr_a, dr_b;
    logic [4:0] cnt_a, cnt_b;
    logic       af_a, af_b, ae_a, ae_b, lk_a, lk_b, fd_a, fd_b, ov_a, ov_b;

    lvds_rx_deframer #(
        .LANES(1), .ZERO_LEN(ZL), .FRAME_LEN(FL_A), .DEPTH_LOG2(DL2), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .in_data(din_a), .rd_en(re_a),
        .rd_data(rdd_a), .rd_valid(rv_a), .rd_dr(dr_a), .data_count(cnt_a),
        .almost_full(af_a), .almost_empty(ae_a), .locked(lk_a), .frame_done(fd_a), .overflow(ov_a)
    );

    lvds_rx_deframer #(
        .LANES(4), .ZERO_LEN(ZL), .FRAME_LEN(FL_B), .DEPTH_LOG2(DL2), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .in_data(din_b), .rd_en(re_b),
        .rd_data(rdd_b), .rd_valid(rv_b), .rd_dr(dr_b), .data_count(cnt_b),
        .almost_full(af_b), .almost_empty(ae_b), .locked(lk_b), .frame_done(fd_b), .overflow(ov_b)
    );

    // Reference model state, index 0 = instance A, 1 = instance B.
    int          m_init [2];
    int          m_run  [2];
    int          m_zc   [2];
    int          m_acnt [2];
    int          m_nb   [2];
    logic [31:0] m_bits [2];
    logic [7:0]  m_fq   [2][DEPTH];
    int          m_fn   [2];
    logic [7:0]  e_rdd  [2];
    logic        e_rv   [2];
    logic        e_fd   [2];
    logic        e_ov   [2];
    logic        e_lk   [2];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int fd_cnt_a = 0;

    task automatic cmp(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Processes one clock edge: bits scanned one at a time, FIFO kept as a plain list.
    task automatic model_edge(input int i, input int bpc, input int flen,
                              input logic [7:0] w, input logic rd, input logic rst_n);
        logic       got, last, full_pre;
        logic [7:0] b;
        got  = 1'b0;
        last = 1'b0;
        b    = '0;
        if (!rst_n) begin
            m_init[i] = 1; m_run[i] = 0; m_zc[i] = 0; m_acnt[i] = 0; m_nb[i] = 0; m_fn[i] = 0;
            e_rdd[i] = '0; e_rv[i] = 1'b0; e_fd[i] = 1'b0; e_ov[i] = 1'b0; e_lk[i] = 1'b0;
            return;
        end
        if (m_init[i] != 0) begin
            m_init[i] = 0;
            m_zc[i]   = 0;
        end else begin
            for (int k = bpc - 1; k >= 0; k--) begin
                if (m_run[i] != 0) begin
                    m_bits[i] = {m_bits[i][30:0], w[k]};
                    m_acnt[i]++;
                end else if (w[k] == 1'b0) begin
                    m_zc[i] = (m_zc[i] < 255) ? m_zc[i] + 1 : 255;
                end else if (m_zc[i] >= ZL) begin
                    m_run[i] = 1; m_acnt[i] = 0; m_nb[i] = 0;
                end else begin
                    m_zc[i] = 0;
                end
            end
            if (m_run[i] != 0 && m_acnt[i] >= 8) begin
                got = 1'b1;
                b   = 8'(m_bits[i] >> (m_acnt[i] - 8));
                m_acnt[i] -= 8;
                m_nb[i]++;
                if (m_nb[i] == flen) begin
                    last = 1'b1;
                    m_run[i] = 0; m_zc[i] = 0; m_acnt[i] = 0; m_nb[i] = 0;
                end
            end
        end
        full_pre = (m_fn[i] == DEPTH);
        e_rv[i]  = 1'b0;
        if (rd && m_fn[i] > 0) begin
            e_rdd[i] = m_fq[i][0];
            for (int j = 0; j < DEPTH - 1; j++) m_fq[i][j] = m_fq[i][j+1];
            m_fn[i]--;
            e_rv[i] = 1'b1;
        end
        if (got) begin
            if (full_pre) e_ov[i] = 1'b1;
            else begin
                m_fq[i][m_fn[i]] = b;
                m_fn[i]++;
            end
        end
        e_fd[i] = last;
        e_lk[i] = (m_run[i] != 0);
    endtask

    always @(posedge clk) begin
        model_edge(0, 2, FL_A, {6'b0, din_a}, re_a, reset_n);
        model_edge(1, 8, FL_B, din_b, re_b, reset_n);
    end

    task automatic check_inst(input int i, input string t, input int cnt, input logic dr,
                              input logic af, input logic ae, input logic lk, input logic fd,
                              input logic ov, input logic rv, input logic [7:0] rdd);
        cmp({t, ".data_count"}, cnt, m_fn[i]);
        cmp({t, ".rd_dr"}, int'(dr), int'(m_fn[i] > 0));
        cmp({t, ".almost_full"}, int'(af), int'(m_fn[i] >= AF));
        cmp({t, ".almost_empty"}, int'(ae), int'(m_fn[i] <= AE));
        cmp({t, ".locked"}, int'(lk), int'(e_lk[i]));
        cmp({t, ".frame_done"}, int'(fd), int'(e_fd[i]));
        cmp({t, ".overflow"}, int'(ov), int'(e_ov[i]));
        cmp({t, ".rd_valid"}, int'(rv), int'(e_rv[i]));
        cmp({t, ".rd_data"}, int'(rdd), int'(e_rdd[i]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, "a", int'(cnt_a), dr_a, af_a, ae_a, lk_a, fd_a, ov_a, rv_a, rdd_a);
            check_inst(1, "b", int'(cnt_b), dr_b, af_b, ae_b, lk_b, fd_b, ov_b, rv_b, rdd_b);
            if (fd_a) fd_cnt_a++;
        end
    end

    task automatic step(input logic [1:0] a, input logic [7:0] b, input logic ra, input logic rb);
        din_a = a; din_b = b; re_a = ra; re_b = rb;
        @(negedge clk);
    endtask

    task automatic send_a(input logic [63:0] s, input int nbits);
        for (int k = nbits - 1; k > 0; k -= 2) step(s[k -: 2], 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        din_a = '0; din_b = '0; re_a = 1'b0; re_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        cmp("rst.a.rd_data", int'(rdd_a), 0);
        cmp("rst.a.almost_empty", int'(ae_a), 1);
        cmp("rst.b.locked", int'(lk_b), 0);
        cmp("rst.b.data_count", int'(cnt_b), 0);
        reset_n = 1'b1;
        step(2'b00, 8'h00, 1'b0, 1'b0);

        // 1 lane: 12 zeros, start bit, A5, 3C, 2-byte frame
        send_a(64'({12'b0, 1'b1, 8'hA5, 8'h3C, 1'b0}), 30);
        cmp("t1.count", int'(cnt_a), 2);
        cmp("t1.locked_drop", int'(lk_a), 0);
        step(2'b00, 8'h00, 1'b0, 1'b0);
        cmp("t1.frame_done_pulses", fd_cnt_a, 1);
        step(2'b00, 8'h00, 1'b1, 1'b0);
        cmp("t1.pop0_valid", int'(rv_a), 1);
        cmp("t1.pop0_data", int'(rdd_a), 'hA5);
        step(2'b00, 8'h00, 1'b1, 1'b0);
        cmp("t1.pop1_data", int'(rdd_a), 'h3C);
        step(2'b00, 8'h00, 1'b0, 1'b0);
        cmp("t1.valid_pulse", int'(rv_a), 0);
        cmp("t1.empty", int'(dr_a), 0);

        // 8 zeros then a 1 must not lock; the following long run does
        send_a(64'({2'b11, 8'b0, 2'b10}), 12);
        cmp("t3.no_lock", int'(lk_a), 0);
        send_a(64'({12'b0, 2'b10}), 14);
        cmp("t3.lock", int'(lk_a), 1);
        send_a(64'({7'b0110011, 8'hC3, 1'b0}), 16);
        cmp("t3.unlock", int'(lk_a), 0);
        step(2'b00, 8'h00, 1'b1, 1'b0);
        cmp("t3.pop0_data", int'(rdd_a), 'h33);
        step(2'b00, 8'h00, 1'b1, 1'b0);
        cmp("t3.pop1_data", int'(rdd_a), 'hC3);

        // 4 lanes: start bit at word bit 5, 0x81 straddles two words; 20-byte frame into 16 slots
        step(2'b00, 8'h00, 1'b0, 1'b0);
        step(2'b00, 8'h30, 1'b0, 1'b0);
        cmp("t2.lock", int'(lk_b), 1);
        step(2'b00, 8'h20, 1'b0, 1'b0);
        cmp("t2.first_byte_count", int'(cnt_b), 1);
        for (int n = 0; n < 19; n++) step(2'b00, 8'($urandom), 1'b0, 1'b0);
        cmp("t4.count_full", int'(cnt_b), 16);
        cmp("t4.overflow", int'(ov_b), 1);
        cmp("t4.unlock", int'(lk_b), 0);
        step(2'b00, 8'h00, 1'b0, 1'b1);
        cmp("t4.pop_valid", int'(rv_b), 1);
        cmp("t2.pop_0x81", int'(rdd_b), 'h81);
        step(2'b00, 8'h00, 1'b0, 1'b0);
        cmp("t4.overflow_sticky", int'(ov_b), 1);

        // Push and pop together at count 16: push dropped
        step(2'b00, 8'h30, 1'b0, 1'b0);
        step(2'b00, 8'h20, 1'b0, 1'b0);
        cmp("t5.count16", int'(cnt_b), 16);
        step(2'b00, 8'h55, 1'b0, 1'b1);
        cmp("t5.count15", int'(cnt_b), 15);
        for (int n = 0; n < 18; n++) step(2'b00, 8'($urandom), 1'b0, 1'b0);

        // Reset mid-RUN on both instances
        send_a(64'({12'b0, 2'b11, 2'b01}), 16);
        step(2'b00, 8'h30, 1'b0, 1'b0);
        cmp("t6.a_locked", int'(lk_a), 1);
        cmp("t6.b_locked", int'(lk_b), 1);
        reset_n = 1'b0;
        step(2'b00, 8'h00, 1'b0, 1'b0);
        cmp("t6.a_locked_rst", int'(lk_a), 0);
        cmp("t6.b_count_rst", int'(cnt_b), 0);
        cmp("t6.b_overflow_rst", int'(ov_b), 0);
        cmp("t6.b_almost_empty_rst", int'(ae_b), 1);
        cmp("t6.b_rd_data_rst", int'(rdd_b), 0);
        reset_n = 1'b1;
        step(2'b00, 8'h00, 1'b0, 1'b0);
        send_a(64'({12'b0, 2'b10}), 14);
        cmp("t6.relock", int'(lk_a), 1);

        // Random traffic with zero-biased words
        for (int c = 0; c < 4000; c++) begin
            logic [1:0] a;
            logic [7:0] b;
            a = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            b = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
